// File: rtl/ip_ram_responder_if.sv
// rtl/ip_ram_responder_if.sv - mapper-side RAM request/response bus
interface ip_ram_responder_if;
  logic        rd;
  logic        wr;
  logic        busy;
  logic [21:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_en;

  // Mapper side: issues level-held requests, receives read data.
  modport master (
    output rd, wr, address, wdata,
    input  busy, rdata, rdata_en
  );

  // Responder side: accepts requests, returns read data.
  modport slave (
    input  rd, wr, address, wdata,
    output busy, rdata, rdata_en
  );
endinterface

// File: rtl/ip_ram_responder.sv
// rtl/ip_ram_responder.sv - converts level-held mapper requests into timed async SRAM accesses
module ip_ram_responder #(
  parameter int ACCESS_CYCLES   = 4,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic                clk,
  input  logic                n_reset,
  ip_ram_responder_if.slave   bus,
  output logic [21:0]         mem_address,
  output logic [7:0]          mem_wdata,
  output logic                mem_wdata_oe,
  input  logic [7:0]          mem_rdata,
  output logic                mem_ce_n,
  output logic                mem_oe_n,
  output logic                mem_we_n
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  // Counter reload values; the counter runs down to zero and stops there.
  localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] REC_LOAD = 4'(RECOVERY_CYCLES - 1);

  state_t      r_state,       w_state_nxt;
  logic [3:0]  r_cnt,         w_cnt_nxt;
  logic        r_armed,       w_armed_nxt;
  logic        r_is_wr,       w_is_wr_nxt;
  logic        r_busy,        w_busy_nxt;
  logic [7:0]  r_rdata,       w_rdata_nxt;
  logic        r_rdata_en,    w_rdata_en_nxt;
  logic [21:0] r_mem_address, w_mem_address_nxt;
  logic [7:0]  r_mem_wdata,   w_mem_wdata_nxt;
  logic        r_wdata_oe,    w_wdata_oe_nxt;
  logic        r_ce_n,        w_ce_n_nxt;
  logic        r_oe_n,        w_oe_n_nxt;
  logic        r_we_n,        w_we_n_nxt;

  logic        w_req;
  logic        w_accept;

  // A request is only taken when the initiator has been seen idle since the last acceptance.
  assign w_req    = bus.rd | bus.wr;
  assign w_accept = (r_state == IDLE) && r_armed && w_req;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_armed_nxt       = r_armed;
    w_is_wr_nxt       = r_is_wr;
    w_rdata_nxt       = r_rdata;
    w_rdata_en_nxt    = 1'b0;
    w_mem_address_nxt = r_mem_address;
    w_mem_wdata_nxt   = r_mem_wdata;

    if (!w_req) begin
      w_armed_nxt = 1'b1;
    end
    if (w_accept) begin
      w_armed_nxt = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt       = SETUP;
          w_mem_address_nxt = bus.address;
          w_mem_wdata_nxt   = bus.wdata;
          // Write wins when both requests are raised together.
          w_is_wr_nxt       = bus.wr;
        end
      end
      SETUP: begin
        w_cnt_nxt   = ACC_LOAD;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (r_cnt == 4'd0) begin
          if (!r_is_wr) begin
            w_rdata_nxt    = mem_rdata;
            w_rdata_en_nxt = 1'b1;
          end
          w_cnt_nxt   = REC_LOAD;
          w_state_nxt = RECOVER;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RECOVER: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // busy lags the state by one edge, so it also covers the first IDLE cycle.
    w_busy_nxt     = (r_state != IDLE) | w_accept;
    // Pin controls are decoded from the next state so they change on the same edge as the state.
    w_ce_n_nxt     = !((w_state_nxt == SETUP) || (w_state_nxt == ACCESS));
    w_oe_n_nxt     = !((w_state_nxt == ACCESS) && !w_is_wr_nxt);
    w_we_n_nxt     = !((w_state_nxt == ACCESS) && w_is_wr_nxt);
    // Data stays driven through RECOVER so it is held past the rising edge of we_n.
    w_wdata_oe_nxt = (w_state_nxt != IDLE) && w_is_wr_nxt;
  end

  // State, counter and all output registers; reset drops every strobe at once.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_armed       <= 1'b0;
      r_is_wr       <= 1'b0;
      r_busy        <= 1'b0;
      r_rdata       <= 8'h00;
      r_rdata_en    <= 1'b0;
      r_mem_address <= 22'h000000;
      r_mem_wdata   <= 8'h00;
      r_wdata_oe    <= 1'b0;
      r_ce_n        <= 1'b1;
      r_oe_n        <= 1'b1;
      r_we_n        <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_armed       <= w_armed_nxt;
      r_is_wr       <= w_is_wr_nxt;
      r_busy        <= w_busy_nxt;
      r_rdata       <= w_rdata_nxt;
      r_rdata_en    <= w_rdata_en_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_wdata_oe    <= w_wdata_oe_nxt;
      r_ce_n        <= w_ce_n_nxt;
      r_oe_n        <= w_oe_n_nxt;
      r_we_n        <= w_we_n_nxt;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.rdata    = r_rdata;
  assign bus.rdata_en = r_rdata_en;
  assign mem_address  = r_mem_address;
  assign mem_wdata    = r_mem_wdata;
  assign mem_wdata_oe = r_wdata_oe;
  assign mem_ce_n     = r_ce_n;
  assign mem_oe_n     = r_oe_n;
  assign mem_we_n     = r_we_n;

endmodule

// File: tb/tb_ip_ram_responder.sv
// tb/tb_ip_ram_responder.sv - directed scoreboard bench for ip_ram_responder
module tb_ip_ram_responder;
  localparam int A0 = 4;
  localparam int R0 = 1;

  logic       clk       = 1'b0;
  logic       n_reset   = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       rd_s      = 1'b0;
  logic       wr_s      = 1'b0;
  logic       sweep_clr = 1'b0;

  int n_pass   = 0;
  int n_total  = 0;
  int rden_cnt = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  // Main instance with default timing.
  ip_ram_responder_if bus0 ();
  wire [21:0] mem_address0;
  wire [7:0]  mem_wdata0;
  wire        mem_wdata_oe0, mem_ce_n0, mem_oe_n0, mem_we_n0;

  ip_ram_responder #(.ACCESS_CYCLES(A0), .RECOVERY_CYCLES(R0)) u_dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .bus          (bus0),
    .mem_address  (mem_address0),
    .mem_wdata    (mem_wdata0),
    .mem_wdata_oe (mem_wdata_oe0),
    .mem_rdata    (mem_rdata),
    .mem_ce_n     (mem_ce_n0),
    .mem_oe_n     (mem_oe_n0),
    .mem_we_n     (mem_we_n0)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic checkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: every rdata_en pops one expected read value.
  always @(negedge clk) begin
    if (n_reset && bus0.rdata_en === 1'b1) begin
      rden_cnt <= rden_cnt + 1;
      if (exp_q.size() == 0) check1("rdata_en_spurious", bus0.rdata_en, 1'b0);
      else checkv("sb_rdata", 32'(bus0.rdata), 32'(exp_q.pop_front()));
    end
  end

  // Sweep instances: (A,R) = (1,1) (1,15) (15,1) (15,15), measured by cycle counters.
  wire [7:0] sw_oe   [4];
  wire [7:0] sw_we   [4];
  wire [7:0] sw_busy [4];
  wire [7:0] sw_rden [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int GA = (g < 2) ? 1 : 15;
    localparam int GR = (g % 2 == 0) ? 1 : 15;
    ip_ram_responder_if bus ();
    wire [21:0] ma;
    wire [7:0]  mw;
    wire        moe, ce_n, oe_n, we_n;
    logic [7:0] n_oe = 8'd0, n_we = 8'd0, n_busy = 8'd0, n_rden = 8'd0;

    assign bus.rd      = rd_s;
    assign bus.wr      = wr_s;
    assign bus.address = 22'h2AAAAA;
    assign bus.wdata   = 8'h5A;

    ip_ram_responder #(.ACCESS_CYCLES(GA), .RECOVERY_CYCLES(GR)) u_sw (
      .clk          (clk),
      .n_reset      (n_reset),
      .bus          (bus),
      .mem_address  (ma),
      .mem_wdata    (mw),
      .mem_wdata_oe (moe),
      .mem_rdata    (8'hC3),
      .mem_ce_n     (ce_n),
      .mem_oe_n     (oe_n),
      .mem_we_n     (we_n)
    );

    // Count strobe-low, busy-high and rdata_en cycles since the last clear.
    always @(negedge clk) begin
      if (sweep_clr) begin
        n_oe <= 8'd0; n_we <= 8'd0; n_busy <= 8'd0; n_rden <= 8'd0;
      end else begin
        if (oe_n === 1'b0) n_oe <= n_oe + 8'd1;
        if (we_n === 1'b0) n_we <= n_we + 8'd1;
        if (bus.busy === 1'b1) n_busy <= n_busy + 8'd1;
        if (bus.rdata_en === 1'b1) n_rden <= n_rden + 8'd1;
      end
    end

    assign sw_oe[g]   = n_oe;
    assign sw_we[g]   = n_we;
    assign sw_busy[g] = n_busy;
    assign sw_rden[g] = n_rden;
  end

  // One access on the main instance, checked cycle by cycle against the timing formulas.
  task automatic do_access(input string nm, input bit is_wr, input bit both,
                           input logic [21:0] a, input logic [7:0] d, input int drop_k);
    bit eff_wr;
    eff_wr = is_wr | both;
    bus0.address = a;
    bus0.wdata   = d;
    bus0.rd      = !is_wr | both;
    bus0.wr      = eff_wr;
    if (!eff_wr) exp_q.push_back(mem_rdata);
    for (int k = 0; k <= 2 + A0 + R0; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus0.address = ~a;
        bus0.wdata   = ~d;
      end
      if (k == drop_k) begin
        bus0.rd = 1'b0;
        bus0.wr = 1'b0;
      end
      check1($sformatf("%s_busy_k%0d", nm, k), bus0.busy, k <= 1 + A0 + R0);
      check1($sformatf("%s_ce_n_k%0d", nm, k), mem_ce_n0, !(k <= A0));
      check1($sformatf("%s_oe_n_k%0d", nm, k), mem_oe_n0, !(!eff_wr && k >= 1 && k <= A0));
      check1($sformatf("%s_we_n_k%0d", nm, k), mem_we_n0, !(eff_wr && k >= 1 && k <= A0));
      check1($sformatf("%s_wdoe_k%0d", nm, k), mem_wdata_oe0, eff_wr && k <= A0 + R0);
      check1($sformatf("%s_rden_k%0d", nm, k), bus0.rdata_en, !eff_wr && k == 1 + A0);
      checkv($sformatf("%s_addr_k%0d", nm, k), 32'(mem_address0), 32'(a));
      if (eff_wr) checkv($sformatf("%s_wdata_k%0d", nm, k), 32'(mem_wdata0), 32'(d));
    end
  endtask

  task automatic check_reset_vals(input string nm);
    check1({nm, "_busy"}, bus0.busy, 1'b0);
    check1({nm, "_rden"}, bus0.rdata_en, 1'b0);
    check1({nm, "_wdoe"}, mem_wdata_oe0, 1'b0);
    checkv({nm, "_rdata"}, 32'(bus0.rdata), 32'h0);
    checkv({nm, "_addr"}, 32'(mem_address0), 32'h0);
    checkv({nm, "_wdata"}, 32'(mem_wdata0), 32'h0);
    check1({nm, "_ce_n"}, mem_ce_n0, 1'b1);
    check1({nm, "_oe_n"}, mem_oe_n0, 1'b1);
    check1({nm, "_we_n"}, mem_we_n0, 1'b1);
  endtask

  initial begin
    int c0;
    int ga;
    int gr;
    bus0.rd = 1'b0; bus0.wr = 1'b0;
    bus0.address = 22'h0; bus0.wdata = 8'h0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    n_reset = 1'b1;
    @(posedge clk); #1;

    // Read with defaults.
    mem_rdata = 8'hA5;
    do_access("read", 1'b0, 1'b0, 22'h012345, 8'h00, 0);

    // Write to the top address.
    do_access("write", 1'b1, 1'b0, 22'h3FFFFF, 8'h3C, 0);

    // Simultaneous rd and wr: one write, no rdata_en.
    c0 = rden_cnt;
    do_access("both", 1'b1, 1'b1, 22'h00F0F0, 8'h96, 0);
    checkv("both_rden_count", 32'(rden_cnt - c0), 32'd0);

    // rd dropped at E0+2: access still completes with rdata_en.
    mem_rdata = 8'h4B;
    c0 = rden_cnt;
    do_access("drop", 1'b0, 1'b0, 22'h1ABCDE, 8'h00, 2);
    checkv("drop_rden_count", 32'(rden_cnt - c0), 32'd1);

    // Held level: exactly one access across 20 cycles, re-arm needs one low edge.
    mem_rdata = 8'h77;
    c0 = rden_cnt;
    bus0.address = 22'h000777;
    exp_q.push_back(8'h77);
    bus0.rd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkv("held_rden_count", 32'(rden_cnt - c0), 32'd1);
    check1("held_busy_idle", bus0.busy, 1'b0);
    check1("held_ce_n_idle", mem_ce_n0, 1'b1);
    bus0.rd = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(8'h77);
    bus0.rd = 1'b1;
    @(posedge clk); #1;
    check1("held_rearm_busy", bus0.busy, 1'b1);
    bus0.rd = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkv("held_rearm_rden_count", 32'(rden_cnt - c0), 32'd2);

    // Reset at E0+2 of a read, with rd held through reset.
    mem_rdata = 8'hE7;
    c0 = rden_cnt;
    bus0.address = 22'h155555;
    bus0.rd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_pre_oe_n", mem_oe_n0, 1'b0);
    n_reset = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(posedge clk); #1;
    n_reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check1("rst_held_busy", bus0.busy, 1'b0);
    check1("rst_held_ce_n", mem_ce_n0, 1'b1);
    checkv("rst_held_rden_count", 32'(rden_cnt - c0), 32'd0);
    bus0.rd = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(8'hE7);
    bus0.rd = 1'b1;
    @(posedge clk); #1;
    check1("rst_rearm_busy", bus0.busy, 1'b1);
    check1("rst_rearm_ce_n", mem_ce_n0, 1'b0);
    bus0.rd = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkv("rst_rearm_rden_count", 32'(rden_cnt - c0), 32'd1);

    // Parameter sweep: one read then one write on each sweep instance.
    for (int op = 0; op < 2; op++) begin
      sweep_clr = 1'b1;
      @(posedge clk); #1;
      sweep_clr = 1'b0;
      if (op == 0) rd_s = 1'b1;
      else wr_s = 1'b1;
      @(posedge clk); #1;
      rd_s = 1'b0;
      wr_s = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) begin
        ga = (g < 2) ? 1 : 15;
        gr = (g % 2 == 0) ? 1 : 15;
        checkv($sformatf("sweep%0d_op%0d_oe_cycles", g, op), 32'(sw_oe[g]), (op == 0) ? 32'(ga) : 32'd0);
        checkv($sformatf("sweep%0d_op%0d_we_cycles", g, op), 32'(sw_we[g]), (op == 1) ? 32'(ga) : 32'd0);
        checkv($sformatf("sweep%0d_op%0d_busy_cycles", g, op), 32'(sw_busy[g]), 32'(2 + ga + gr));
        checkv($sformatf("sweep%0d_op%0d_rden", g, op), 32'(sw_rden[g]), (op == 0) ? 32'd1 : 32'd0);
      end
    end

    checkv("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
